// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - state encoding and default parameters shared by the pattern generator and checker
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    localparam int PKT_LEN_DEF  = 1024;
    localparam int WRAP_VAL_DEF = 1310720;

endpackage

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - packetised incrementing-counter AXI4-Stream source with start/stop control
module axis_pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int PKT_LEN    = PKT_LEN_DEF,
    parameter int WRAP_VAL   = WRAP_VAL_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic              AXI_CLk,
    input  logic              AXI_RST,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [31:0]       i_pkt_num,
    output logic [DATA_W-1:0] M_AXIS_tdata,
    output logic [7:0]        M_AXIS_tkeep,
    output logic              M_AXIS_tlast,
    output logic              M_AXIS_tvalid,
    input  logic              M_AXIS_tready,
    output logic              o_busy,
    output logic [31:0]       o_pkt_cnt,
    output logic [31:0]       o_beat_cnt
);

    localparam logic [DATA_W-1:0] DATA_LAST = DATA_W'(WRAP_VAL - 1);
    localparam logic [31:0]       BEAT_LAST = 32'(PKT_LEN - 1);
    localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYCLES - 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] data_cnt, data_cnt_n;
    logic [31:0]       beat_idx, beat_idx_n;
    logic [31:0]       pkt_num, pkt_num_n;
    logic [31:0]       pkt_cnt, pkt_cnt_n;
    logic [31:0]       beat_cnt, beat_cnt_n;
    logic [31:0]       gap_cnt, gap_cnt_n;
    logic              stop_pend, stop_pend_n;
    logic              xfer, last_beat, run_done;

    always_comb begin
        state_n     = state;
        data_cnt_n  = data_cnt;
        beat_idx_n  = beat_idx;
        pkt_num_n   = pkt_num;
        pkt_cnt_n   = pkt_cnt;
        beat_cnt_n  = beat_cnt;
        gap_cnt_n   = gap_cnt;
        stop_pend_n = stop_pend;
        xfer        = (state == RUN) && M_AXIS_tready;
        last_beat   = (beat_idx == BEAT_LAST);
        run_done    = stop_pend || ((pkt_num != 32'd0) && (pkt_cnt + 32'd1 == pkt_num));

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n     = RUN;
                    pkt_num_n   = i_pkt_num;
                    pkt_cnt_n   = 32'd0;
                    beat_idx_n  = 32'd0;
                    stop_pend_n = 1'b0;
                end
            end
            RUN: begin
                if (i_stop) stop_pend_n = 1'b1;
                if (xfer) begin
                    data_cnt_n = (data_cnt == DATA_LAST) ? '0 : data_cnt + DATA_W'(1);
                    beat_idx_n = beat_idx + 32'd1;
                    beat_cnt_n = beat_cnt + 32'd1;
                    if (last_beat) begin
                        pkt_cnt_n  = pkt_cnt + 32'd1;
                        beat_idx_n = 32'd0;
                        if (run_done) begin
                            state_n     = IDLE;
                            stop_pend_n = 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state_n   = GAP;
                            gap_cnt_n = 32'd0;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt + 32'd1;
                if (i_stop) stop_pend_n = 1'b1;
                // A stop landing in the final gap cycle still suppresses the next packet.
                if (gap_cnt == GAP_LAST) begin
                    if (stop_pend || i_stop) begin
                        state_n     = IDLE;
                        stop_pend_n = 1'b0;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge AXI_CLk) begin
        if (AXI_RST) begin
            state         <= IDLE;
            data_cnt      <= '0;
            beat_idx      <= 32'd0;
            pkt_num       <= 32'd0;
            pkt_cnt       <= 32'd0;
            beat_cnt      <= 32'd0;
            gap_cnt       <= 32'd0;
            stop_pend     <= 1'b0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_n;
            data_cnt      <= data_cnt_n;
            beat_idx      <= beat_idx_n;
            pkt_num       <= pkt_num_n;
            pkt_cnt       <= pkt_cnt_n;
            beat_cnt      <= beat_cnt_n;
            gap_cnt       <= gap_cnt_n;
            stop_pend     <= stop_pend_n;
            M_AXIS_tvalid <= (state_n == RUN);
            M_AXIS_tlast  <= (state_n == RUN) && (beat_idx_n == BEAT_LAST);
            o_busy        <= (state_n != IDLE);
        end
    end

    assign M_AXIS_tdata = data_cnt;
    assign M_AXIS_tkeep = 8'hFF;
    assign o_pkt_cnt    = pkt_cnt;
    assign o_beat_cnt   = beat_cnt;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - directed self-checking bench for axis_pattern_gen
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_stop = 1'b0, a_tready = 1'b1;
    logic [31:0] a_pkt_num = 32'd0;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep;
    logic        a_tlast, a_tvalid, a_busy;
    logic [31:0] a_pkt_cnt, a_beat_cnt;

    logic        b_start = 1'b0, b_stop = 1'b0, b_tready = 1'b1;
    logic [31:0] b_pkt_num = 32'd0;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
    logic        b_tlast, b_tvalid, b_busy;
    logic [31:0] b_pkt_cnt, b_beat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    axis_pattern_gen #(.PKT_LEN(4), .WRAP_VAL(10), .GAP_CYCLES(0)) u_dut (
        .AXI_CLk(clk), .AXI_RST(rst), .i_start(a_start), .i_stop(a_stop), .i_pkt_num(a_pkt_num),
        .M_AXIS_tdata(a_tdata), .M_AXIS_tkeep(a_tkeep), .M_AXIS_tlast(a_tlast),
        .M_AXIS_tvalid(a_tvalid), .M_AXIS_tready(a_tready), .o_busy(a_busy),
        .o_pkt_cnt(a_pkt_cnt), .o_beat_cnt(a_beat_cnt)
    );

    axis_pattern_gen #(.PKT_LEN(4), .WRAP_VAL(10), .GAP_CYCLES(3)) u_dut_gap (
        .AXI_CLk(clk), .AXI_RST(rst), .i_start(b_start), .i_stop(b_stop), .i_pkt_num(b_pkt_num),
        .M_AXIS_tdata(b_tdata), .M_AXIS_tkeep(b_tkeep), .M_AXIS_tlast(b_tlast),
        .M_AXIS_tvalid(b_tvalid), .M_AXIS_tready(b_tready), .o_busy(b_busy),
        .o_pkt_cnt(b_pkt_cnt), .o_beat_cnt(b_beat_cnt)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %0h want 0", a_tvalid); end
        n_cmp++; if (a_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %0h want 0", a_tlast); end
        n_cmp++; if (a_tdata !== 64'd0) begin n_err++; $display("FAIL reset_tdata: got %0h want 0", a_tdata); end
        n_cmp++; if (a_tkeep !== 8'hFF) begin n_err++; $display("FAIL reset_tkeep: got %0h want ff", a_tkeep); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd0) begin n_err++; $display("FAIL reset_pkt_cnt: got %0d want 0", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d want 0", a_beat_cnt); end
        n_cmp++; if (b_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_gap_tvalid: got %0h want 0", b_tvalid); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic el;
        a_pkt_num = 32'd2; a_tready = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            el = (i % 4 == 3);
            n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL basic_tvalid[%0d]: got %0h want 1", i, a_tvalid); end
            n_cmp++; if (a_tdata !== 64'(i)) begin n_err++; $display("FAIL basic_tdata[%0d]: got %0d want %0d", i, a_tdata, i); end
            n_cmp++; if (a_tlast !== el) begin n_err++; $display("FAIL basic_tlast[%0d]: got %0h want %0h", i, a_tlast, el); end
            n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy[%0d]: got %0h want 1", i, a_busy); end
            @(negedge clk);
        end
        n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_end_tvalid: got %0h want 0", a_tvalid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd2) begin n_err++; $display("FAIL basic_pkt_cnt: got %0d want 2", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd8) begin n_err++; $display("FAIL basic_beat_cnt: got %0d want 8", a_beat_cnt); end
    endtask

    task automatic test_backpressure();
        int    k = 0;
        int    cyc = 0;
        longint exp_d = 8;
        logic  el;
        a_pkt_num = 32'd3; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while (k < 12 && cyc < 200) begin
            cyc++;
            el = (k % 4 == 3);
            n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid[%0d]: got %0h want 1", k, a_tvalid); end
            n_cmp++; if (a_tdata !== 64'(exp_d)) begin n_err++; $display("FAIL bp_tdata[%0d]: got %0d want %0d", k, a_tdata, exp_d); end
            n_cmp++; if (a_tlast !== el) begin n_err++; $display("FAIL bp_tlast[%0d]: got %0h want %0h", k, a_tlast, el); end
            a_tready = 1'($urandom_range(0, 1));
            if (a_tready) begin
                k++;
                exp_d = (exp_d == 9) ? 0 : exp_d + 1;
            end
            @(negedge clk);
        end
        a_tready = 1'b1;
        n_cmp++; if (k != 12) begin n_err++; $display("FAIL bp_timeout: got %0d beats want 12", k); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL bp_end_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd3) begin n_err++; $display("FAIL bp_pkt_cnt: got %0d want 3", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd20) begin n_err++; $display("FAIL bp_beat_cnt: got %0d want 20", a_beat_cnt); end
    endtask

    task automatic test_wrap_stop();
        logic el;
        a_pkt_num = 32'd0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            el = (i % 4 == 3);
            n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL wrap_tvalid[%0d]: got %0h want 1", i, a_tvalid); end
            n_cmp++; if (a_tdata !== 64'(i % 10)) begin n_err++; $display("FAIL wrap_tdata[%0d]: got %0d want %0d", i, a_tdata, i % 10); end
            n_cmp++; if (a_tlast !== el) begin n_err++; $display("FAIL wrap_tlast[%0d]: got %0h want %0h", i, a_tlast, el); end
            a_stop = (i == 21);
            @(negedge clk);
        end
        a_stop = 1'b0;
        n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL stop_tvalid: got %0h want 0", a_tvalid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd6) begin n_err++; $display("FAIL stop_pkt_cnt: got %0d want 6", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd44) begin n_err++; $display("FAIL stop_beat_cnt: got %0d want 44", a_beat_cnt); end

        // restart with a simultaneous stop (ignored) and a mid-run start (ignored)
        a_pkt_num = 32'd2; a_start = 1'b1; a_stop = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_stop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            el = (i % 4 == 3);
            n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL resume_tvalid[%0d]: got %0h want 1", i, a_tvalid); end
            n_cmp++; if (a_tdata !== 64'((4 + i) % 10)) begin n_err++; $display("FAIL resume_tdata[%0d]: got %0d want %0d", i, a_tdata, (4 + i) % 10); end
            n_cmp++; if (a_tlast !== el) begin n_err++; $display("FAIL resume_tlast[%0d]: got %0h want %0h", i, a_tlast, el); end
            a_start = (i == 2);
            if (i == 2) a_pkt_num = 32'd5;
            @(negedge clk);
        end
        a_start = 1'b0;
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL resume_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd2) begin n_err++; $display("FAIL resume_pkt_cnt: got %0d want 2", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd52) begin n_err++; $display("FAIL resume_beat_cnt: got %0d want 52", a_beat_cnt); end
    endtask

    task automatic test_gap();
        int   d = 0;
        logic ev;
        logic el;
        b_pkt_num = 32'd0; b_tready = 1'b1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            ev = (c < 4) || (c >= 7 && c < 11);
            n_cmp++; if (b_tvalid !== ev) begin n_err++; $display("FAIL gap_tvalid[%0d]: got %0h want %0h", c, b_tvalid, ev); end
            if (ev) begin
                el = (d % 4 == 3);
                n_cmp++; if (b_tdata !== 64'(d)) begin n_err++; $display("FAIL gap_tdata[%0d]: got %0d want %0d", c, b_tdata, d); end
                n_cmp++; if (b_tlast !== el) begin n_err++; $display("FAIL gap_tlast[%0d]: got %0h want %0h", c, b_tlast, el); end
                d++;
            end
            b_stop = (c == 12);
            @(negedge clk);
        end
        n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL gap_busy: got %0h want 0", b_busy); end
        n_cmp++; if (b_pkt_cnt !== 32'd2) begin n_err++; $display("FAIL gap_pkt_cnt: got %0d want 2", b_pkt_cnt); end
        n_cmp++; if (b_beat_cnt !== 32'd8) begin n_err++; $display("FAIL gap_beat_cnt: got %0d want 8", b_beat_cnt); end
    endtask

    task automatic test_reset_mid();
        a_pkt_num = 32'd0; a_tready = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_cmp++; if (a_tdata !== 64'd2) begin n_err++; $display("FAIL rmid_first: got %0d want 2", a_tdata); end
        @(negedge clk);
        a_tready = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL rmid_stall_tvalid: got %0h want 1", a_tvalid); end
        n_cmp++; if (a_tdata !== 64'd3) begin n_err++; $display("FAIL rmid_stall_tdata: got %0d want 3", a_tdata); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_tvalid: got %0h want 0", a_tvalid); end
        n_cmp++; if (a_tdata !== 64'd0) begin n_err++; $display("FAIL rmid_tdata: got %0d want 0", a_tdata); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %0h want 0", a_busy); end
        n_cmp++; if (a_pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rmid_pkt_cnt: got %0d want 0", a_pkt_cnt); end
        n_cmp++; if (a_beat_cnt !== 32'd0) begin n_err++; $display("FAIL rmid_beat_cnt: got %0d want 0", a_beat_cnt); end
        rst = 1'b0; a_tready = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_cmp++; if (a_tvalid !== 1'b1) begin n_err++; $display("FAIL rmid_restart_tvalid: got %0h want 1", a_tvalid); end
        n_cmp++; if (a_tdata !== 64'd0) begin n_err++; $display("FAIL rmid_restart_tdata: got %0d want 0", a_tdata); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_stop();
        test_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
